wbm_spi_ctrl: RTL and testbench

Wishbone-domain sequencer behind the SPI slave receive path. Consumes bytes already imported from the SPI clock domain, decodes a command/address byte plus optional data byte, and runs one classic Wishbone master cycle per command. Read results go out as one byte on a valid/ready stream to the SPI transmit path.

---
 rtl/wbm_spi_ctrl_pkg.sv | 20 ++
 rtl/wbm_spi_ctrl.sv | 165 ++++++++++++++++
 tb/tb_wbm_spi_ctrl.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wbm_spi_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// wbm_spi_ctrl_pkg
// Shared definitions for the SPI-slave-to-Wishbone-master sequencer:
//   state_e      - sequencer states (encoding visible on the debug port)
//   CMD_WE_BIT   - bit of the command byte that selects a write
//   TIMEOUT_BYTE - response byte sent when a read times out
// ---------------------------------------------------------------------------
package wbm_spi_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GET_DATA = 2'd1,
        WB_REQ   = 2'd2,
        TX_WAIT  = 2'd3
    } state_e;

    localparam int         CMD_WE_BIT   = 7;
    localparam logic [7:0] TIMEOUT_BYTE = 8'hFF;

endpackage

// File: rtl/wbm_spi_ctrl.sv
// ---------------------------------------------------------------------------
// wbm_spi_ctrl
// Wishbone-domain sequencer behind the SPI slave receive path. Decodes a
// command byte (bit7 = write, low ADDR_W bits = address) plus, for writes,
// one data byte, then runs a single classic Wishbone cycle. Read data is
// returned as one byte on the tx stream.
//
// Optional feature: define WBM_SPI_CTRL_TIMEOUT_EN to abandon a Wishbone
// cycle after TIMEOUT un-acked cycles (reads then answer TIMEOUT_BYTE).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_stb, rx_data       one-cycle byte strobe from the SPI rx path
//   tx_valid, tx_ready,   response byte stream. Handshake: a byte moves on
//   tx_data               every edge where tx_valid && tx_ready; once raised,
//                         tx_valid and tx_data stay stable until accepted.
//   wb_cyc_o, wb_stb_o,   classic Wishbone master (cyc == stb throughout)
//   wb_we_o, wb_adr_o,
//   wb_dat_o, wb_dat_i,
//   wb_ack_i
//   overrun               one-cycle pulse: an rx byte arrived while busy
//   dbg_state_o           current sequencer state (state_e encoding)
// ---------------------------------------------------------------------------
module wbm_spi_ctrl
    import wbm_spi_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_stb,
    input  logic [7:0]        rx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [7:0]        wb_dat_o,
    input  logic [7:0]        wb_dat_i,
    input  logic              wb_ack_i,
    output logic              overrun,
    output logic [1:0]        dbg_state_o
);

    if (ADDR_W < 1 || ADDR_W > 7) begin : g_bad_addr_w
        $error("wbm_spi_ctrl: ADDR_W must be in 1..7");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("wbm_spi_ctrl: TIMEOUT must be at least 1");
    end

    state_e              state_q;
    logic                tx_valid_q;
    logic [7:0]          tx_data_q;
    logic                cyc_q;
    logic                we_q;
    logic [ADDR_W-1:0]   adr_q;
    logic [7:0]          dat_q;
    logic                overrun_q;
    logic                timeout_hit;

`ifdef WBM_SPI_CTRL_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Held at zero outside WB_REQ, so it is clear on every entry. On the
    // k-th WB_REQ cycle it reads k-1; the cycle reading TIMEOUT-1 is the
    // last one the strobe is shown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q != WB_REQ) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (cnt_q == CNT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= 8'h00;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (rx_stb) begin
                        adr_q <= rx_data[ADDR_W-1:0];
                        if (rx_data[CMD_WE_BIT]) begin
                            state_q <= GET_DATA;
                        end else begin
                            // Reads start the bus cycle straight from the command byte.
                            cyc_q   <= 1'b1;
                            we_q    <= 1'b0;
                            state_q <= WB_REQ;
                        end
                    end
                end
                GET_DATA: begin
                    if (rx_stb) begin
                        dat_q   <= rx_data;
                        cyc_q   <= 1'b1;
                        we_q    <= 1'b1;
                        state_q <= WB_REQ;
                    end
                end
                WB_REQ: begin
                    if (rx_stb) begin
                        overrun_q <= 1'b1;
                    end
                    // An ack arriving on the timeout cycle still delivers its data.
                    if (wb_ack_i || timeout_hit) begin
                        cyc_q <= 1'b0;
                        we_q  <= 1'b0;
                        if (we_q) begin
                            state_q <= IDLE;
                        end else begin
                            tx_data_q  <= wb_ack_i ? wb_dat_i : TIMEOUT_BYTE;
                            tx_valid_q <= 1'b1;
                            state_q    <= TX_WAIT;
                        end
                    end
                end
                TX_WAIT: begin
                    if (rx_stb) begin
                        overrun_q <= 1'b1;
                    end
                    // tx_valid is always high in this state.
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_we_o     = we_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign overrun     = overrun_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wbm_spi_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wbm_spi_ctrl
// Directed bench for wbm_spi_ctrl. A transaction-level model predicts the
// Wishbone cycles (from the command bytes sent) and the response bytes
// (from the data the bench slave returns); one compare process checks the
// DUT against it every cycle. Directed tests add literal expectations.
// Define WBM_SPI_CTRL_TIMEOUT_EN to include the timeout tests.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wbm_spi_ctrl;
    import wbm_spi_ctrl_pkg::*;

    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 4;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] adr;
        logic [7:0]        dat;
    } wb_txn_t;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] dat;
        int         lat;
    } vec_t;

    // ---------------- clock / reset / DUT ----------------
    logic              clk;
    logic              rst_n;
    logic              rx_stb;
    logic [7:0]        rx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        tx_data;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [ADDR_W-1:0] wb_adr_o;
    logic [7:0]        wb_dat_o;
    logic [7:0]        wb_dat_i;
    logic              wb_ack_i;
    logic              overrun;
    logic [1:0]        dbg_state;

    wbm_spi_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_stb     (rx_stb),
        .rx_data    (rx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .overrun    (overrun),
        .dbg_state_o(dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, time %0t required < 200us", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- bench Wishbone slave ----------------
    // Acks after the strobe has been visible for ack_lat+1 cycles.
    bit         ack_en    = 1'b1;
    int         ack_lat   = 0;
    logic [7:0] slv_rdata = 8'h00;
    int         slv_cnt   = 0;

    always begin
        @(posedge clk);
        #1;
        if (rst_n && ack_en && wb_cyc_o && wb_stb_o) begin
            if (slv_cnt == ack_lat) begin
                wb_ack_i = 1'b1;
                slv_cnt  = 0;
            end else begin
                wb_ack_i = 1'b0;
                slv_cnt++;
            end
        end else begin
            wb_ack_i = 1'b0;
            slv_cnt  = 0;
        end
        wb_dat_i = wb_ack_i ? slv_rdata : 8'hEE;
    end

    // ---------------- model / scoreboard ----------------
    wb_txn_t    exp_wb_q[$];
    logic [7:0] exp_tx_q[$];

    wb_txn_t    cur;
    logic [7:0] tx_hold;
    logic [7:0] last_tx       = 8'h00;
    bit         prev_stb      = 1'b0;
    bit         prev_txv      = 1'b0;
    bit         ended_ok      = 1'b0;
    bit         txv_must_drop = 1'b0;
    int         stb_len       = 0;
    int         last_stb_len  = 0;
    int         tx_hs_cnt     = 0;
    int         txv_cycles    = 0;
    int         ovr_cnt       = 0;

    // Command byte -> expected bus transaction, by plain arithmetic.
    task automatic expect_wb(input logic [7:0] cmd, input logic [7:0] d);
        wb_txn_t t;
        t.we  = (cmd >= 8'h80);
        t.adr = ADDR_W'(cmd % (1 << ADDR_W));
        t.dat = d;
        exp_wb_q.push_back(t);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stb      = 1'b0;
            prev_txv      = 1'b0;
            ended_ok      = 1'b0;
            txv_must_drop = 1'b0;
        end else begin
            chk("cyc_eq_stb", 32'(wb_cyc_o), 32'(wb_stb_o));
            if (!wb_stb_o) chk("we_low_when_idle", 32'(wb_we_o), 32'd0);

            if (wb_stb_o && prev_stb) begin
                if (ended_ok) chk("stb_held_after_end", 32'(wb_stb_o), 32'd0);
                chk("adr_stable", 32'(wb_adr_o), 32'(cur.adr));
                chk("we_stable", 32'(wb_we_o), 32'(cur.we));
                if (cur.we) chk("dat_stable", 32'(wb_dat_o), 32'(cur.dat));
            end

            if (wb_stb_o && !prev_stb) begin
                ended_ok = 1'b0;
                stb_len  = 0;
                if (exp_wb_q.size() == 0) begin
                    chk("wb_unexpected_cycle", 32'(wb_stb_o), 32'd0);
                end else begin
                    cur = exp_wb_q.pop_front();
                    chk("wb_adr", 32'(wb_adr_o), 32'(cur.adr));
                    chk("wb_we", 32'(wb_we_o), 32'(cur.we));
                    if (cur.we) chk("wb_dat", 32'(wb_dat_o), 32'(cur.dat));
                end
            end

            if (!wb_stb_o && prev_stb) begin
                last_stb_len = stb_len;
                chk("stb_drop_legal", 32'(ended_ok), 32'd1);
            end

            if (wb_stb_o) begin
                stb_len++;
                if (wb_ack_i) begin
                    ended_ok = 1'b1;
                    if (!cur.we) exp_tx_q.push_back(wb_dat_i);
                end
`ifdef WBM_SPI_CTRL_TIMEOUT_EN
                else if (stb_len == TIMEOUT) begin
                    ended_ok = 1'b1;
                    if (!cur.we) exp_tx_q.push_back(TIMEOUT_BYTE);
                end
`endif
            end

            if (txv_must_drop) begin
                chk("txv_low_after_accept", 32'(tx_valid), 32'd0);
                txv_must_drop = 1'b0;
            end else if (tx_valid && !prev_txv) begin
                if (exp_tx_q.size() == 0) begin
                    chk("tx_unexpected", 32'(tx_valid), 32'd0);
                end else begin
                    tx_hold = exp_tx_q.pop_front();
                    chk("tx_data", 32'(tx_data), 32'(tx_hold));
                end
            end else if (tx_valid && prev_txv) begin
                chk("tx_data_stable", 32'(tx_data), 32'(tx_hold));
            end

            if (tx_valid) begin
                txv_cycles++;
                if (tx_ready) begin
                    tx_hs_cnt++;
                    last_tx       = tx_data;
                    txv_must_drop = 1'b1;
                end
            end
            if (overrun) ovr_cnt++;

            prev_stb = wb_stb_o;
            prev_txv = tx_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_data = b;
        rx_stb  = 1'b1;
        step(1);
        rx_stb  = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while ((wb_cyc_o || tx_valid) && k < budget) begin
            step(1);
            k++;
        end
        chk({"done_", name}, 32'(wb_cyc_o || tx_valid), 32'd0);
        step(1);
    endtask

    task automatic wait_txv(input int budget, input string name);
        int k = 0;
        while (!tx_valid && k < budget) begin
            step(1);
            k++;
        end
        chk({"txv_seen_", name}, 32'(tx_valid), 32'd1);
    endtask

    vec_t vecs[4];
    int   b_hs, b_txv, b_ovr;

    // ---------------- directed tests ----------------
    initial begin
        rst_n    = 1'b0;
        rx_stb   = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        wb_ack_i = 1'b0;
        wb_dat_i = 8'h00;
        vecs[0] = '{cmd: 8'h8C, dat: 8'hF0, lat: 1};
        vecs[1] = '{cmd: 8'h0C, dat: 8'h96, lat: 2};
        vecs[2] = '{cmd: 8'hF1, dat: 8'h00, lat: 0};
        vecs[3] = '{cmd: 8'h40, dat: 8'h01, lat: 0};
        step(3);

        // Reset values
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_we", 32'(wb_we_o), 32'd0);
        chk("rst_adr", 32'(wb_adr_o), 32'd0);
        chk("rst_dat", 32'(wb_dat_o), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        step(2);

        // Write 0x83 / 0x5A, ack after 2 wait cycles
        ack_lat = 2;
        b_txv   = txv_cycles;
        expect_wb(8'h83, 8'h5A);
        rx_byte(8'h83);
        chk("wr_no_stb_before_data", 32'(wb_stb_o), 32'd0);
        rx_byte(8'h5A);
        chk("wr_cyc", 32'(wb_cyc_o), 32'd1);
        chk("wr_stb", 32'(wb_stb_o), 32'd1);
        chk("wr_we", 32'(wb_we_o), 32'd1);
        chk("wr_adr", 32'(wb_adr_o), 32'd3);
        chk("wr_dat", 32'(wb_dat_o), 32'h5A);
        wait_done(20, "wr");
        chk("wr_stb_len", 32'(last_stb_len), 32'd3);
        chk("wr_no_tx", 32'(txv_cycles - b_txv), 32'd0);

        // Read 0x02 -> 0xC3, ack after 1 wait cycle, tx_ready high
        ack_lat   = 1;
        slv_rdata = 8'hC3;
        b_hs      = tx_hs_cnt;
        b_txv     = txv_cycles;
        expect_wb(8'h02, 8'h00);
        rx_byte(8'h02);
        chk("rd_stb_next_cycle", 32'(wb_stb_o), 32'd1);
        chk("rd_we", 32'(wb_we_o), 32'd0);
        chk("rd_adr", 32'(wb_adr_o), 32'd2);
        wait_done(20, "rd");
        chk("rd_stb_len", 32'(last_stb_len), 32'd2);
        chk("rd_tx_byte", 32'(last_tx), 32'hC3);
        chk("rd_txv_one_cycle", 32'(txv_cycles - b_txv), 32'd1);
        chk("rd_one_hs", 32'(tx_hs_cnt - b_hs), 32'd1);

        // Backpressure: tx_ready low for 5 cycles, rx byte meanwhile is dropped
        tx_ready = 1'b0;
        b_hs     = tx_hs_cnt;
        b_txv    = txv_cycles;
        b_ovr    = ovr_cnt;
        expect_wb(8'h02, 8'h00);
        rx_byte(8'h02);
        wait_txv(20, "bp");
        for (int i = 0; i < 5; i++) begin
            chk("bp_txv_held", 32'(tx_valid), 32'd1);
            chk("bp_data_held", 32'(tx_data), 32'hC3);
            if (i == 1) rx_byte(8'h81);
            else step(1);
        end
        chk("bp_overrun", 32'(ovr_cnt - b_ovr), 32'd1);
        chk("bp_no_new_cycle", 32'(wb_stb_o), 32'd0);
        tx_ready = 1'b1;
        wait_done(20, "bp");
        chk("bp_txv_len", 32'(txv_cycles - b_txv), 32'd6);
        chk("bp_one_hs", 32'(tx_hs_cnt - b_hs), 32'd1);

        // Reserved command bits ignored
        ack_lat   = 0;
        slv_rdata = 8'h3C;
        expect_wb(8'h7F, 8'h00);
        rx_byte(8'h7F);
        chk("rsv_adr", 32'(wb_adr_o), 32'hF);
        chk("rsv_we", 32'(wb_we_o), 32'd0);
        wait_done(20, "rsv");
        chk("rsv_tx_byte", 32'(last_tx), 32'h3C);

        // Overrun during WB_REQ, then write with immediate turnaround
        ack_lat   = 3;
        slv_rdata = 8'hA5;
        b_ovr     = ovr_cnt;
        expect_wb(8'h05, 8'h00);
        rx_byte(8'h05);
        rx_byte(8'h9E);
        wait_done(20, "ovr");
        chk("ovr_pulse", 32'(ovr_cnt - b_ovr), 32'd1);
        chk("ovr_tx_byte", 32'(last_tx), 32'hA5);
        ack_lat   = 0;
        slv_rdata = 8'h77;
        expect_wb(8'h86, 8'h11);
        expect_wb(8'h09, 8'h00);
        rx_byte(8'h86);
        rx_byte(8'h11);
        step(1);            // ack sampled at this edge; IDLE entered
        rx_byte(8'h09);     // accepted in the IDLE entry cycle
        chk("turn_stb", 32'(wb_stb_o), 32'd1);
        chk("turn_adr", 32'(wb_adr_o), 32'd9);
        wait_done(20, "turn");
        chk("turn_tx_byte", 32'(last_tx), 32'h77);

        // Directed vector table
        for (int i = 0; i < 4; i++) begin
            ack_lat   = vecs[i].lat;
            slv_rdata = vecs[i].dat;
            if (vecs[i].cmd[7]) begin
                expect_wb(vecs[i].cmd, vecs[i].dat);
                rx_byte(vecs[i].cmd);
                rx_byte(vecs[i].dat);
            end else begin
                expect_wb(vecs[i].cmd, 8'h00);
                rx_byte(vecs[i].cmd);
            end
            wait_done(20, "vec");
            chk("vec_stb_len", 32'(last_stb_len), 32'(vecs[i].lat + 1));
        end

        // Reset in WB_REQ: cyc/stb drop without a clock edge
        ack_en = 1'b0;
        expect_wb(8'h04, 8'h00);
        rx_byte(8'h04);
        chk("mid_stb_up", 32'(wb_stb_o), 32'd1);
        step(2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("mid_rst_stb", 32'(wb_stb_o), 32'd0);
        exp_wb_q.delete();
        step(2);
        rst_n     = 1'b1;
        ack_en    = 1'b1;
        ack_lat   = 1;
        slv_rdata = 8'h5E;
        step(1);
        expect_wb(8'h01, 8'h00);
        rx_byte(8'h01);
        chk("post_rst_adr", 32'(wb_adr_o), 32'd1);
        wait_done(20, "post_rst");
        chk("post_rst_tx_byte", 32'(last_tx), 32'h5E);

        // Reset in TX_WAIT: pending byte is lost
        tx_ready  = 1'b0;
        ack_lat   = 0;
        slv_rdata = 8'h99;
        b_hs      = tx_hs_cnt;
        expect_wb(8'h02, 8'h00);
        rx_byte(8'h02);
        wait_txv(20, "txw_rst");
        rst_n = 1'b0;
        #1;
        chk("txw_rst_txv", 32'(tx_valid), 32'd0);
        exp_tx_q.delete();
        step(1);
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        step(2);
        chk("txw_rst_no_hs", 32'(tx_hs_cnt - b_hs), 32'd0);

`ifdef WBM_SPI_CTRL_TIMEOUT_EN
        // Read with no ack times out and answers 0xFF
        ack_en = 1'b0;
        expect_wb(8'h03, 8'h00);
        rx_byte(8'h03);
        wait_done(20, "to_rd");
        chk("to_rd_stb_len", 32'(last_stb_len), 32'(TIMEOUT));
        chk("to_rd_tx_byte", 32'(last_tx), 32'hFF);
        // Write with no ack times out silently
        b_hs = tx_hs_cnt;
        expect_wb(8'h8A, 8'h33);
        rx_byte(8'h8A);
        rx_byte(8'h33);
        wait_done(20, "to_wr");
        chk("to_wr_stb_len", 32'(last_stb_len), 32'(TIMEOUT));
        chk("to_wr_no_tx", 32'(tx_hs_cnt - b_hs), 32'd0);
        // Ack on the timeout cycle wins
        ack_en    = 1'b1;
        ack_lat   = TIMEOUT - 1;
        slv_rdata = 8'h4B;
        expect_wb(8'h03, 8'h00);
        rx_byte(8'h03);
        wait_done(20, "to_ack");
        chk("to_ack_stb_len", 32'(last_stb_len), 32'(TIMEOUT));
        chk("to_ack_tx_byte", 32'(last_tx), 32'h4B);
`endif

        step(3);
        chk("wb_queue_drained", 32'(exp_wb_q.size()), 32'd0);
        chk("tx_queue_drained", 32'(exp_tx_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
